full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port a  input  WIDTH  addend A, unsigned (signed for overflow only).
REQ-005 Port b  input  WIDTH  addend B.
REQ-006 Port c0  input  1  carry-in.
REQ-007 Port in_vld  input  1  operands valid this cycle.
REQ-008 Port s  output  WIDTH  registered sum.
REQ-009 Port c  output  1  registered carry-out.
REQ-010 Port out_vld  output  1  s/c hold a new result this cycle.
REQ-011 Port ovf  output  1  registered signed overflow; present only when FULL_ADDER_OVF_EN is defined.

Function
REQ-012 Result = a + b + c0 computed at WIDTH+1 bits; s = low WIDTH bits, c = bit WIDTH.
REQ-013 Adder SHALL be a ripple chain of 1-bit cells: s_i = a_i ^ b_i ^ cin_i; cout_i = a_i&b_i | cin_i&(a_i^b_i); cin_0 = c0.
REQ-014 Latency exactly 1 cycle: operands sampled at edge N with in_vld=1 appear on s/c at edge N, out_vld=1 during cycle N+1.
REQ-015 Edge with in_vld=0: s, c (and ovf) SHALL hold previous values; out_vld SHALL be 0.
REQ-016 Back-to-back in_vld=1 SHALL give one result per cycle, no bubbles, no stall.
REQ-017 Wrap-around: all-ones + all-ones + 1 -> s = all-ones, c = 1; all-ones + 0 + 1 -> s = 0, c = 1.
REQ-018 No X propagation from unused state: outputs SHALL be defined from the first edge after reset.
REQ-019 All outputs driven by flops; no combinational path input -> output.

Reset
REQ-020 rst=1 at a rising edge SHALL set s=0, c=0, out_vld=0 (ovf=0 if present).
REQ-021 rst has priority over in_vld; an operand presented in the same cycle as rst SHALL be discarded.
REQ-022 First result after rst deasserts SHALL require a fresh in_vld=1 edge; no pending result survives reset.

Configuration
REQ-023 Macro FULL_ADDER_OVF_EN: when defined, port ovf exists and is registered with s/c, ovf = (a[MSB]==b[MSB]) & (s[MSB]!=a[MSB]), held when in_vld=0.
REQ-024 Without FULL_ADDER_OVF_EN: no ovf port, no overflow logic; all other behaviour identical.

Verification
REQ-025 WIDTH=1, c0=0 then 1, sweep a,b over 00,01,10,11 with in_vld=1 -> next cycle (s,c) = 00,10,10,01 for c0=0 and 10,01,01,11 for c0=1.
REQ-026 WIDTH=4, a=4'hF, b=4'h1, c0=0 -> s=4'h0, c=1, out_vld=1 one cycle later.
REQ-027 WIDTH=4, in_vld=1 for a=3,b=4,c0=1 then in_vld=0 with a=9 -> s=8 held, c=0, out_vld 1 then 0.
REQ-028 Assert rst during stream of in_vld=1 -> s=0, c=0, out_vld=0 next edge; input in reset cycle never appears on outputs.
REQ-029 FULL_ADDER_OVF_EN defined, WIDTH=4, a=4'h7, b=4'h1, c0=0 -> s=4'h8, c=0, ovf=1; a=4'h8, b=4'h8 -> s=0, c=1, ovf=1.
REQ-030 WIDTH=8 random back-to-back stream of 1000 operands -> every result matches a+b+c0 at 1-cycle latency, out_vld continuous.

Source files
------------

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with valid handshake and one-cycle latency.
// Optional signed-overflow output enabled by defining FULL_ADDER_OVF_EN.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c0,
   input  logic             in_vld,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             out_vld
`ifdef FULL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH-1:0] sum_nxt;
   logic             cout_nxt;

   // Each loop iteration is one 1-bit cell; the carry ripples LSB to MSB.
   always_comb begin : ripple
      logic carry;
      carry   = c0;
      sum_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_nxt[i] = a[i] ^ b[i] ^ carry;
         carry      = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout_nxt = carry;
   end

`ifdef FULL_ADDER_OVF_EN
   logic ovf_nxt;

   assign ovf_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (sum_nxt[WIDTH-1] != a[WIDTH-1]);
`endif

   // Reset wins over in_vld, so an operand arriving with rst is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         s       <= '0;
         c       <= 1'b0;
         out_vld <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         out_vld <= in_vld;
         if (in_vld) begin
            s   <= sum_nxt;
            c   <= cout_nxt;
`ifdef FULL_ADDER_OVF_EN
            ovf <= ovf_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 4 and 8; expectations come from an
// arithmetic model and are queued at drive time, popped when out_vld is due.
module tb_full_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       a1 = '0, b1 = '0, c01 = 1'b0, v1 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       c04 = 1'b0, v4 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       c08 = 1'b0, v8 = 1'b0;

   logic       s1, cy1, vo1, of1;
   logic [3:0] s4;
   logic       cy4, vo4, of4;
   logic [7:0] s8;
   logic       cy8, vo8, of8;

`ifndef FULL_ADDER_OVF_EN
   assign of1 = 1'b0;
   assign of4 = 1'b0;
   assign of8 = 1'b0;
`endif

   full_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c0(c01), .in_vld(v1),
      .s(s1), .c(cy1), .out_vld(vo1)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(of1)
`endif
   );

   full_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .c0(c04), .in_vld(v4),
      .s(s4), .c(cy4), .out_vld(vo4)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(of4)
`endif
   );

   full_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .c0(c08), .in_vld(v8),
      .s(s8), .c(cy8), .out_vld(vo8)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(of8)
`endif
   );

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q1[$], q4[$], q8[$];
   exp_t l1 = '0, l4 = '0, l8 = '0;

   // Independent arithmetic reference: integer sum and signed-range overflow test.
   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic ci);
      exp_t e;
      int   ua, ub, sa, sb, tot, ssum;
      ua   = int'(a) & ((1 << w) - 1);
      ub   = int'(b) & ((1 << w) - 1);
      tot  = ua + ub + int'(ci);
      sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      ssum = sa + sb + int'(ci);
      e.s  = 8'(tot & ((1 << w) - 1));
      e.c  = ((tot >> w) & 1) != 0;
      e.o  = (ssum > (1 << (w - 1)) - 1) || (ssum < -(1 << (w - 1)));
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag, input logic [7:0] s_obs, input logic c_obs,
                        input logic o_obs, input logic vld_obs, input logic vld_exp,
                        input exp_t e);
      chk({tag, ".out_vld"}, 64'(vld_obs), 64'(vld_exp));
      chk({tag, ".s"}, 64'(s_obs), 64'(e.s));
      chk({tag, ".c"}, 64'(c_obs), 64'(e.c));
`ifdef FULL_ADDER_OVF_EN
      chk({tag, ".ovf"}, 64'(o_obs), 64'(e.o));
`endif
   endtask

   task automatic step1(input string tag, input logic want);
      tick();
      if (want) l1 = q1.pop_front();
      check(tag, 8'(s1), cy1, of1, vo1, want, l1);
   endtask

   task automatic step4(input string tag, input logic want);
      tick();
      if (want) l4 = q4.pop_front();
      check(tag, 8'(s4), cy4, of4, vo4, want, l4);
   endtask

   task automatic step8(input string tag, input logic want);
      tick();
      if (want) l8 = q8.pop_front();
      check(tag, s8, cy8, of8, vo8, want, l8);
   endtask

   task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      a4 = a; b4 = b; c04 = ci; v4 = 1'b1;
      q4.push_back(model(4, 8'(a), 8'(b), ci));
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      a8 = a; b8 = b; c08 = ci; v8 = 1'b1;
      q8.push_back(model(8, a, b, ci));
   endtask

   initial begin
      // Reset state on all three widths
      rst = 1'b1;
      tick();
      step1("rst_w1", 1'b0);
      check("rst_w4", 8'(s4), cy4, of4, vo4, 1'b0, '0);
      check("rst_w8", s8, cy8, of8, vo8, 1'b0, '0);
      rst = 1'b0;

      // WIDTH=1 truth table, c0=0 then c0=1
      for (int ci = 0; ci < 2; ci++) begin
         for (int ab = 0; ab < 4; ab++) begin
            a1 = ab[1]; b1 = ab[0]; c01 = ci[0]; v1 = 1'b1;
            q1.push_back(model(1, 8'(ab[1]), 8'(ab[0]), ci[0]));
            step1($sformatf("w1_c%0d_ab%0d", ci, ab), 1'b1);
         end
      end
      v1 = 1'b0;
      step1("w1_idle", 1'b0);

      // WIDTH=4 wrap-around cases
      drive4(4'hF, 4'h1, 1'b0);
      step4("w4_f_plus_1", 1'b1);
      drive4(4'hF, 4'hF, 1'b1);
      step4("w4_ones_ones_1", 1'b1);
      drive4(4'hF, 4'h0, 1'b1);
      step4("w4_ones_0_1", 1'b1);

      // Result holds while in_vld is low, even with new operands on the pins
      drive4(4'h3, 4'h4, 1'b1);
      step4("w4_3_4_1", 1'b1);
      a4 = 4'h9; v4 = 1'b0;
      step4("w4_hold1", 1'b0);
      step4("w4_hold2", 1'b0);

      // Signed overflow corner cases
      drive4(4'h7, 4'h1, 1'b0);
      step4("w4_ovf_pos", 1'b1);
      drive4(4'h8, 4'h8, 1'b0);
      step4("w4_ovf_neg", 1'b1);
      drive4(4'h7, 4'h8, 1'b1);
      step4("w4_no_ovf_mixed", 1'b1);
      v4 = 1'b0;
      step4("w4_ovf_hold", 1'b0);

      // Reset in the middle of a WIDTH=8 stream drops the in-flight operand
      drive8(8'h12, 8'h34, 1'b0);
      step8("w8_pre0", 1'b1);
      drive8(8'hFF, 8'h01, 1'b1);
      step8("w8_pre1", 1'b1);
      a8 = 8'hAA; b8 = 8'h55; c08 = 1'b1; v8 = 1'b1;
      rst = 1'b1;
      q1.delete(); q4.delete(); q8.delete();
      l1 = '0; l4 = '0; l8 = '0;
      step8("w8_in_rst", 1'b0);
      check("w4_in_rst", 8'(s4), cy4, of4, vo4, 1'b0, l4);
      rst = 1'b0; v8 = 1'b0;
      step8("w8_post_rst", 1'b0);
      drive8(8'h80, 8'h80, 1'b0);
      step8("w8_fresh", 1'b1);

      // 1000 random back-to-back operands, out_vld must stay high throughout
      for (int i = 0; i < 1000; i++) begin
         drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         step8($sformatf("w8_rand%0d", i), 1'b1);
      end
      v8 = 1'b0;
      step8("w8_drain", 1'b0);
      chk("w8_queue_empty", 64'(q8.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
